fir_filter_ctrl: RTL and testbench
==================================

# fir_filter_ctrl

Sequencing controller in front of `fir_filter`. Owns the filter's sample-input and coefficient shift-in ports. Arbitrates between streaming samples and reloading coefficients, so the coefficient shift register is never disturbed while samples are in flight. After each reload it can optionally flush stale taps with zero samples.

## Interface
- `DATA_WIDTH`, 16: sample and coefficient width; must match the filter.
- `NUM_TAPS`, 16: filter tap count; ≥2.
- `CNT_WIDTH`, 32: width of `sample_count`.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `cfg_start`  in  1  one-cycle request to begin a coefficient reload
- `cfg_coeff_valid`  in  1  coefficient stream valid
- `cfg_coeff_ready`  out  1  coefficient stream ready
- `cfg_coeff`  in  DATA_WIDTH  coefficient word
- `cfg_done`  out  1  one-cycle pulse when a reload completes
- `s_valid`  in  1  sample stream valid
- `s_ready`  out  1  sample stream ready
- `s_data`  in  DATA_WIDTH  sample
- `fir_input_valid`  out  1  to filter `input_valid`
- `fir_x`  out  DATA_WIDTH  to filter `x`
- `fir_coeff_valid`  out  1  to filter `coeff_valid`
- `fir_coeff_in`  out  DATA_WIDTH  to filter `coeff_in`
- `busy`  out  1  high in any state other than RUN
- `sample_count`  out  CNT_WIDTH  samples accepted since reset; wraps

## Operation
States and transitions:
- **RUN** (reset state)
  - `s_ready`=1; `fir_input_valid`=`s_valid`; `fir_x`=`s_data`.
  - `cfg_start`=1 → DRAIN. A sample presented in the same cycle is still accepted.
- **DRAIN**
  - Lasts exactly 2 cycles (counter 0→1).
  - Matches the filter's 2-cycle valid pipeline, so the last outputs are produced with the old coefficients.
  - → LOAD.
- **LOAD**
  - `cfg_coeff_ready`=1; `fir_coeff_valid`=`cfg_coeff_valid`; `fir_coeff_in`=`cfg_coeff`.
  - Tap counter increments per accepted word.
  - The first accepted word ends in tap NUM_TAPS-1; the last ends in tap 0.
  - Accept with counter==NUM_TAPS-1 → FLUSH (macro on) or RUN (macro off).
  - `cfg_done` pulses in the cycle the state becomes RUN.
- **FLUSH**
  - `fir_input_valid`=1, `fir_x`=0 for exactly NUM_TAPS cycles.
  - → RUN with `cfg_done` pulse.

Rules:
- `cfg_start` is ignored outside RUN.
- `s_ready`=0 and samples are stalled in DRAIN, LOAD and FLUSH.
- `cfg_coeff_ready`=0 outside LOAD.
- `fir_coeff_valid` is never high outside LOAD.
- `sample_count` increments on `s_valid & s_ready` only. Flush zeros are not counted. It wraps from 2^CNT_WIDTH-1 to 0.
- Gaps in `cfg_coeff_valid` during LOAD simply hold the counter. There is no timeout.

## Timing
- All `fir_*` outputs, `s_ready` and `cfg_coeff_ready` are combinational from the state register and inputs. There are zero cycles of added latency between an accepted sample and `fir_input_valid`.
- Reload cost, macro on: 2 + (NUM_TAPS accepted words) + NUM_TAPS cycles. Macro off: 2 + NUM_TAPS words.
- Reset values:
  - state RUN; counters 0; `cfg_done`=0; `busy`=0; `sample_count`=0.
  - While `reset` is high: `s_ready`, `cfg_coeff_ready`, `fir_input_valid` and `fir_coeff_valid` are forced 0.
- Reset mid-LOAD/FLUSH:
  - Returns to RUN immediately and `cfg_done` is not pulsed.
  - Filter coefficients may be partially shifted. The host must issue a new reload.
- `cfg_start` high on the same edge that `reset` deasserts is ignored.

## Configuration
- `FIR_FILTER_CTRL_FLUSH_EN`
  - **Defined:** FLUSH state present; taps are zeroed after each reload, so the first post-reload output uses only new samples.
  - **Undefined:** LOAD → RUN directly; taps keep pre-reload samples, and the first NUM_TAPS-1 outputs mix old data with the new coefficients. FLUSH logic and its counter are removed.

## Test plan
- Reset, stream 5 samples 1..5 back-to-back → `fir_input_valid` high 5 cycles with `fir_x`=1..5; `sample_count`=5; `busy`=0.
- In RUN, `cfg_start` with `s_valid`=1 in the same cycle → that sample is accepted; `s_ready`=0 for 2 DRAIN cycles; then `cfg_coeff_ready`=1.
- NUM_TAPS=4, load words 4,3,2,1 with one idle cycle between each → exactly 4 `fir_coeff_valid` pulses. Filter coefficient for tap 0 is 1 and for tap 3 is 4. `cfg_done` pulses once.
- Macro on, after load → 4 consecutive cycles of `fir_input_valid`=1, `fir_x`=0. `sample_count` unchanged. Impulse of 1 then yields filter outputs 1,2,3,4.
- Assert `reset` after 2 of 4 coefficients → state RUN, `cfg_done` never pulses, `s_ready`=1 one cycle after deassertion.
- `sample_count` preset near wrap (CNT_WIDTH=4, 16 samples) → count reads 0 after the 16th; `cfg_start` pulsed in LOAD is ignored.

Source files
------------

// File: rtl/fir_filter_ctrl.sv
// Sequencing controller in front of fir_filter: arbitrates sample streaming vs coefficient reload.
// Latency: zero cycles from an accepted sample or coefficient to the fir_* outputs; cfg_done is registered.
// Backpressure: s_ready drops outside RUN; cfg_coeff_ready is high only in LOAD.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   cfg_start               one-cycle reload request (honoured in RUN only)
//   cfg_coeff_*             coefficient stream (valid/ready), forwarded to the filter in LOAD
//   cfg_done                one-cycle pulse when a reload completes
//   s_valid/s_ready/s_data  sample stream, forwarded to the filter in RUN
//   fir_input_valid, fir_x  filter sample port
//   fir_coeff_valid, fir_coeff_in  filter coefficient shift-in port
//   busy                    high in any state other than RUN
//   sample_count            samples accepted since reset, wraps
//
// Build option: define FIR_FILTER_CTRL_FLUSH_EN to add the FLUSH state, which shifts
// NUM_TAPS zero samples into the filter after each reload.

module fir_filter_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_TAPS   = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_start,
    input  logic                  cfg_coeff_valid,
    output logic                  cfg_coeff_ready,
    input  logic [DATA_WIDTH-1:0] cfg_coeff,
    output logic                  cfg_done,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  fir_input_valid,
    output logic [DATA_WIDTH-1:0] fir_x,
    output logic                  fir_coeff_valid,
    output logic [DATA_WIDTH-1:0] fir_coeff_in,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  sample_count
);

    localparam int TAP_W = (NUM_TAPS > 2) ? $clog2(NUM_TAPS) : 1;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    logic [1:0]           state_q, state_d;
    logic                 drain_cnt_q, drain_cnt_d;
    logic [TAP_W-1:0]     tap_cnt_q, tap_cnt_d;
    logic                 cfg_done_q, cfg_done_d;
    logic [CNT_WIDTH-1:0] sample_count_q, sample_count_d;
`ifdef FIR_FILTER_CTRL_FLUSH_EN
    logic [TAP_W-1:0]     flush_cnt_q, flush_cnt_d;
`endif

    logic s_acc;
    logic coeff_acc;

    // Handshake outputs are forced low while reset is held so nothing reaches
    // the filter before the controller is out of reset.
    assign s_ready         = ~reset & (state_q == ST_RUN);
    assign cfg_coeff_ready = ~reset & (state_q == ST_LOAD);
    assign fir_input_valid = ~reset & (((state_q == ST_RUN) & s_valid) | (state_q == ST_FLUSH));
    assign fir_x           = (state_q == ST_RUN) ? s_data : '0;
    assign fir_coeff_valid = cfg_coeff_ready & cfg_coeff_valid;
    assign fir_coeff_in    = cfg_coeff;

    assign s_acc     = s_valid & s_ready;
    assign coeff_acc = fir_coeff_valid;

    assign busy         = (state_q != ST_RUN);
    assign cfg_done     = cfg_done_q;
    assign sample_count = sample_count_q;

    always_comb begin
        state_d        = state_q;
        drain_cnt_d    = drain_cnt_q;
        tap_cnt_d      = tap_cnt_q;
        cfg_done_d     = 1'b0;
        sample_count_d = sample_count_q + {{(CNT_WIDTH-1){1'b0}}, s_acc};
`ifdef FIR_FILTER_CTRL_FLUSH_EN
        flush_cnt_d    = flush_cnt_q;
`endif
        case (state_q)
            ST_RUN: begin
                // A sample in the same cycle as cfg_start is still accepted (s_ready=1 here).
                if (cfg_start) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                // Two idle cycles let the filter's valid pipeline finish on the old coefficients.
                if (drain_cnt_q) begin
                    state_d   = ST_LOAD;
                    tap_cnt_d = '0;
                end else begin
                    drain_cnt_d = 1'b1;
                end
            end
            ST_LOAD: begin
                if (coeff_acc) begin
                    if (tap_cnt_q == LAST_TAP) begin
                        tap_cnt_d = '0;
`ifdef FIR_FILTER_CTRL_FLUSH_EN
                        state_d     = ST_FLUSH;
                        flush_cnt_d = '0;
`else
                        state_d    = ST_RUN;
                        cfg_done_d = 1'b1;
`endif
                    end else begin
                        tap_cnt_d = tap_cnt_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
`ifdef FIR_FILTER_CTRL_FLUSH_EN
                if (flush_cnt_q == LAST_TAP) begin
                    state_d    = ST_RUN;
                    cfg_done_d = 1'b1;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
`else
                state_d = ST_RUN;
`endif
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_RUN;
            drain_cnt_q    <= 1'b0;
            tap_cnt_q      <= '0;
            cfg_done_q     <= 1'b0;
            sample_count_q <= '0;
        end else begin
            state_q        <= state_d;
            drain_cnt_q    <= drain_cnt_d;
            tap_cnt_q      <= tap_cnt_d;
            cfg_done_q     <= cfg_done_d;
            sample_count_q <= sample_count_d;
        end
    end

`ifdef FIR_FILTER_CTRL_FLUSH_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_cnt_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_fir_filter_ctrl.sv
// Bench for fir_filter_ctrl with NUM_TAPS=4, CNT_WIDTH=4.
// Latency: inputs driven 1 time unit after the rising edge, outputs checked 4 units after it.
// Backpressure: exercised through stalls in DRAIN/LOAD/FLUSH and coefficient gaps.

module tb_fir_filter_ctrl;

    localparam int DW = 16;
    localparam int NT = 4;
    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          cfg_start;
    logic          cfg_coeff_valid;
    logic          cfg_coeff_ready;
    logic [DW-1:0] cfg_coeff;
    logic          cfg_done;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          fir_input_valid;
    logic [DW-1:0] fir_x;
    logic          fir_coeff_valid;
    logic [DW-1:0] fir_coeff_in;
    logic          busy;
    logic [CW-1:0] sample_count;

    fir_filter_ctrl #(.DATA_WIDTH(DW), .NUM_TAPS(NT), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .cfg_start(cfg_start), .cfg_coeff_valid(cfg_coeff_valid),
        .cfg_coeff_ready(cfg_coeff_ready), .cfg_coeff(cfg_coeff), .cfg_done(cfg_done),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .fir_input_valid(fir_input_valid), .fir_x(fir_x),
        .fir_coeff_valid(fir_coeff_valid), .fir_coeff_in(fir_coeff_in),
        .busy(busy), .sample_count(sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cnt_model = 0;     // accepted samples since last reset
    int sent[$];           // values the filter should have seen on its sample port
    int done_seen = 0;

    // Behavioural filter sitting on the fir_* ports (tap 0 = newest).
    int f_c[NT] = '{default: 0};
    int f_x[NT] = '{default: 0};
    always @(negedge clk) begin
        if (fir_coeff_valid === 1'b1) begin
            for (int i = NT - 1; i > 0; i--) f_c[i] = f_c[i-1];
            f_c[0] = int'(fir_coeff_in);
        end
        if (fir_input_valid === 1'b1) begin
            for (int i = NT - 1; i > 0; i--) f_x[i] = f_x[i-1];
            f_x[0] = int'(fir_x);
        end
    end

    function automatic int filter_y();
        int y = 0;
        for (int i = 0; i < NT; i++) y += f_c[i] * f_x[i];
        return y;
    endfunction

    // Expected output with coefficients 4,3,2,1 loaded: tap i holds i+1.
    function automatic int expected_y();
        int y = 0;
        int n = sent.size();
        for (int i = 0; i < NT; i++)
            if (n - 1 - i >= 0) y += (i + 1) * sent[n-1-i];
        return y;
    endfunction

    always @(posedge clk) begin
        #2;
        if (cfg_done === 1'b1) done_seen++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_start = 1'b0; cfg_coeff_valid = 1'b0; cfg_coeff = '0;
        s_valid = 1'b0; s_data = '0;
    endtask

    task automatic check_count(input string name);
        logic [CW-1:0] exp_cnt;
        exp_cnt = cnt_model[CW-1:0];
        checks++;
        if (sample_count !== exp_cnt) begin
            errors++;
            $display("FAIL %s sample_count got %0d want %0d", name, sample_count, exp_cnt);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        s_valid = 1'b1; s_data = 16'h1234; cfg_coeff_valid = 1'b1;
        repeat (2) tick();
        #3;
        checks++;
        if ({s_ready, cfg_coeff_ready, fir_input_valid, fir_coeff_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_forced got %b want 0000",
                     {s_ready, cfg_coeff_ready, fir_input_valid, fir_coeff_valid});
        end
        checks++;
        if ({busy, cfg_done} !== 2'b00) begin
            errors++; $display("FAIL reset_busy_done got %b want 00", {busy, cfg_done});
        end
        cnt_model = 0;
        check_count("reset");
        tick();
        reset = 1'b0;
        idle_inputs();
        tick();
        #3;
        checks++;
        if ({s_ready, busy, cfg_coeff_ready} !== 3'b100) begin
            errors++; $display("FAIL post_reset got %b want 100", {s_ready, busy, cfg_coeff_ready});
        end
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 5; i++) begin
            s_valid = 1'b1; s_data = DW'(i);
            #3;
            checks++;
            if ({s_ready, fir_input_valid} !== 2'b11 || fir_x !== DW'(i)) begin
                errors++;
                $display("FAIL stream_%0d got rdy=%b vld=%b x=%0d want 1 1 %0d",
                         i, s_ready, fir_input_valid, fir_x, i);
            end
            sent.push_back(i); cnt_model++;
            tick();
        end
        idle_inputs();
        #3;
        check_count("stream5");
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL stream_busy got %b want 0", busy); end
        tick();
    endtask

    task automatic test_random_stream(input int n);
        int bad = 0;
        for (int k = 0; k < n; k++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data = DW'($urandom_range(0, 65535));
            #3;
            checks++;
            if (s_ready !== 1'b1 || fir_input_valid !== s_valid ||
                (s_valid && fir_x !== s_data)) begin
                errors++; bad++;
                if (bad < 5)
                    $display("FAIL rand_stream got rdy=%b vld=%b x=%h want 1 %b %h",
                             s_ready, fir_input_valid, fir_x, s_valid, s_data);
            end
            if (s_valid) begin sent.push_back(int'(s_data)); cnt_model++; end
            tick();
        end
        idle_inputs();
        #3;
        check_count("rand_stream");
        tick();
    endtask

    task automatic test_reload(input bit rand_gaps);
        int done0 = done_seen;
        int pulses = 0;
        int gap;
        logic [DW-1:0] d;
        // Request in RUN with a sample in the same cycle
        d = DW'($urandom_range(0, 65535));
        cfg_start = 1'b1; s_valid = 1'b1; s_data = d;
        #3;
        checks++;
        if ({s_ready, fir_input_valid} !== 2'b11 || fir_x !== d) begin
            errors++; $display("FAIL start_sample got rdy=%b vld=%b x=%h want 1 1 %h",
                               s_ready, fir_input_valid, fir_x, d);
        end
        sent.push_back(int'(d)); cnt_model++;
        tick();
        // DRAIN: two stalled cycles; a repeated cfg_start and a stray coefficient are ignored
        for (int c = 0; c < 2; c++) begin
            cfg_start = (c == 0); cfg_coeff_valid = 1'b1; cfg_coeff = 16'hdead;
            #3;
            checks++;
            if ({s_ready, fir_input_valid, cfg_coeff_ready, fir_coeff_valid, busy} !== 5'b00001) begin
                errors++; $display("FAIL drain_%0d got %b want 00001", c,
                    {s_ready, fir_input_valid, cfg_coeff_ready, fir_coeff_valid, busy});
            end
            tick();
        end
        cfg_start = 1'b0;
        // LOAD: words NT..1 with gaps
        for (int w = 0; w < NT; w++) begin
            gap = rand_gaps ? $urandom_range(0, 2) : 1;
            for (int g = 0; g < gap; g++) begin
                cfg_coeff_valid = 1'b0; cfg_start = (w == 1);
                #3;
                checks++;
                if ({cfg_coeff_ready, fir_coeff_valid, s_ready, cfg_done} !== 4'b1000) begin
                    errors++; $display("FAIL load_gap_%0d got %b want 1000", w,
                        {cfg_coeff_ready, fir_coeff_valid, s_ready, cfg_done});
                end
                tick();
            end
            cfg_start = 1'b0;
            cfg_coeff_valid = 1'b1; cfg_coeff = DW'(NT - w);
            #3;
            checks++;
            if ({cfg_coeff_ready, fir_coeff_valid} !== 2'b11 || fir_coeff_in !== DW'(NT - w)) begin
                errors++; $display("FAIL load_word_%0d got rdy=%b vld=%b c=%0d want 1 1 %0d",
                                   w, cfg_coeff_ready, fir_coeff_valid, fir_coeff_in, NT - w);
            end
            if (fir_coeff_valid === 1'b1) pulses++;
            tick();
        end
        checks++;
        if (pulses != NT) begin errors++; $display("FAIL coeff_pulses got %0d want %0d", pulses, NT); end
`ifdef FIR_FILTER_CTRL_FLUSH_EN
        for (int f = 0; f < NT; f++) begin
            s_valid = 1'b1; s_data = 16'hbeef; cfg_coeff_valid = 1'b1;
            #3;
            checks++;
            if ({fir_input_valid, s_ready, cfg_coeff_ready, fir_coeff_valid, cfg_done} !== 5'b10000 ||
                fir_x !== '0) begin
                errors++; $display("FAIL flush_%0d got %b x=%h want 10000 x=0", f,
                    {fir_input_valid, s_ready, cfg_coeff_ready, fir_coeff_valid, cfg_done}, fir_x);
            end
            sent.push_back(0);
            tick();
        end
`endif
        idle_inputs();
        #3;
        checks++;
        if ({cfg_done, busy, s_ready} !== 3'b101) begin
            errors++; $display("FAIL reload_done got %b want 101", {cfg_done, busy, s_ready});
        end
        check_count("reload");
        tick();
        #3;
        checks++;
        if (cfg_done !== 1'b0 || done_seen - done0 != 1) begin
            errors++; $display("FAIL done_pulse got done=%b pulses=%0d want 0 1", cfg_done, done_seen - done0);
        end
        checks++;
        if (f_c[0] != 1 || f_c[NT-1] != NT) begin
            errors++; $display("FAIL coeff_taps got t0=%0d t%0d=%0d want 1 %0d", f_c[0], NT-1, f_c[NT-1], NT);
        end
        tick();
    endtask

    task automatic test_impulse();
        int y;
        for (int k = 0; k < NT; k++) begin
            s_valid = 1'b1; s_data = (k == 0) ? DW'(1) : '0;
            sent.push_back((k == 0) ? 1 : 0); cnt_model++;
            tick();
            idle_inputs();
            #3;
            y = expected_y();
            checks++;
            if (filter_y() != y) begin
                errors++; $display("FAIL impulse_%0d y got %0d want %0d", k, filter_y(), y);
            end
`ifdef FIR_FILTER_CTRL_FLUSH_EN
            checks++;
            if (filter_y() != k + 1) begin
                errors++; $display("FAIL impulse_clean_%0d y got %0d want %0d", k, filter_y(), k + 1);
            end
`endif
        end
        check_count("impulse");
        tick();
    endtask

    task automatic test_reset_mid_load();
        int done0 = done_seen;
        cfg_start = 1'b1;
        tick();
        cnt_model += 0;
        cfg_start = 1'b0;
        repeat (2) tick();
        for (int w = 0; w < 2; w++) begin
            cfg_coeff_valid = 1'b1; cfg_coeff = DW'(9);
            tick();
        end
        reset = 1'b1; s_valid = 1'b1; cfg_coeff_valid = 1'b1;
        #3;
        checks++;
        if ({s_ready, cfg_coeff_ready, fir_input_valid, fir_coeff_valid, busy} !== 5'b00000) begin
            errors++; $display("FAIL midload_reset got %b want 00000",
                {s_ready, cfg_coeff_ready, fir_input_valid, fir_coeff_valid, busy});
        end
        cnt_model = 0;
        check_count("midload_reset");
        tick();
        reset = 1'b0;
        idle_inputs();
        tick();
        #3;
        checks++;
        if ({s_ready, busy, cfg_done} !== 3'b100) begin
            errors++; $display("FAIL midload_after got %b want 100", {s_ready, busy, cfg_done});
        end
        repeat (NT + 3) tick();
        checks++;
        if (done_seen != done0) begin
            errors++; $display("FAIL midload_no_done got %0d pulses want 0", done_seen - done0);
        end
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 16; i++) begin
            s_valid = 1'b1; s_data = DW'($urandom_range(0, 65535));
            cnt_model++;
            tick();
            if (i == 15) begin
                idle_inputs(); #3; check_count("wrap_15"); tick();
            end
        end
        idle_inputs();
        #3;
        checks++;
        if (sample_count !== '0) begin
            errors++; $display("FAIL wrap_16 sample_count got %0d want 0", sample_count);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_reload(1'b0);
        test_impulse();
        test_random_stream(30);
        test_reload(1'b1);
        test_impulse();
        test_reset_mid_load();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
